fetch_sequencer: RTL and testbench

//  Multi-cycle program sequencer for the 9-bit core. Owns the PC, fetches from synchronous instruction memory, and presents each instruction to the control unit.

---
 rtl/fetch_sequencer.sv | 173 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multi-cycle fetch/decode/exec sequencer with data-memory handshake and branch-target LUT
// Optional SEQ_PERF_CNT_EN adds saturating cyc_cnt / instr_cnt performance counters.
module fetch_sequencer #(
    parameter int              PC_W       = 10,
    parameter int              LUT_DEPTH  = 32,
    parameter logic [PC_W-1:0] START_PC   = '0,
    parameter logic [8:0]      HALT_INSTR = 9'h1FF,
    parameter int              MEM_TMO    = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            done,
    output logic            err,
    output logic            imem_rd_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_data,
    output logic [8:0]      instr,
    output logic            instr_valid,
    output logic            commit,
    input  logic            branch_en,
    input  logic [4:0]      branch_idx,
    input  logic            mem_access,
    output logic            dmem_req,
    input  logic            dmem_ack,
    input  logic            lut_wr_en,
    input  logic [4:0]      lut_wr_idx,
`ifdef SEQ_PERF_CNT_EN
    input  logic [PC_W-1:0] lut_wr_data,
    output logic [31:0]     cyc_cnt,
    output logic [31:0]     instr_cnt
`else
    input  logic [PC_W-1:0] lut_wr_data
`endif
);

    localparam int WC_W = $clog2(MEM_TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_MEMWAIT = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [WC_W-1:0] wait_cnt;
    logic [PC_W-1:0] lut [LUT_DEPTH];
    logic [PC_W-1:0] next_pc;
    logic            is_halt;
    logic            parked;
    logic            restart;
    logic            exec_mem;

    assign is_halt  = (instr == HALT_INSTR);
    assign parked   = (state == S_IDLE) || (state == S_HALT);
    assign restart  = parked && start;
    assign exec_mem = (state == S_EXEC) && !is_halt && mem_access;
    assign next_pc  = branch_en ? lut[branch_idx] : pc + PC_W'(1);

    assign imem_addr = pc;

    // commit and dmem_req react to same-cycle control-unit / memory inputs,
    // and dmem_req must fall the moment reset forces the state to IDLE.
    assign commit   = ((state == S_EXEC) && !is_halt && !mem_access) ||
                      ((state == S_MEMWAIT) && dmem_ack);
    assign dmem_req = exec_mem || (state == S_MEMWAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= START_PC;
            instr       <= '0;
            wait_cnt    <= '0;
            err         <= 1'b0;
            done        <= 1'b0;
            imem_rd_en  <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state      <= S_FETCH;
                        pc         <= START_PC;
                        err        <= 1'b0;
                        done       <= 1'b0;
                        imem_rd_en <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state      <= S_DECODE;
                    imem_rd_en <= 1'b0;
                end
                S_DECODE: begin
                    instr       <= imem_data;
                    state       <= S_EXEC;
                    instr_valid <= 1'b1;
                end
                S_EXEC: begin
                    if (is_halt) begin
                        state       <= S_HALT;
                        done        <= 1'b1;
                        instr_valid <= 1'b0;
                    end else if (mem_access) begin
                        state    <= S_MEMWAIT;
                        wait_cnt <= WC_W'(1);
                    end else begin
                        state       <= S_FETCH;
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        imem_rd_en  <= 1'b1;
                    end
                end
                S_MEMWAIT: begin
                    // An ack in the final allowed cycle still commits.
                    if (dmem_ack) begin
                        state       <= S_FETCH;
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        imem_rd_en  <= 1'b1;
                    end else if (wait_cnt == WC_W'(MEM_TMO)) begin
                        state       <= S_HALT;
                        err         <= 1'b1;
                        done        <= 1'b1;
                        instr_valid <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    done        <= 1'b0;
                    imem_rd_en  <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    // Target table is only writable while no program is running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut[i] <= '0;
            end
        end else if (lut_wr_en && parked) begin
            lut[lut_wr_idx] <= lut_wr_data;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
        end else if (restart) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
        end else begin
            if (!parked && (cyc_cnt != '1)) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (commit && (instr_cnt != '1)) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed table-driven bench for fetch_sequencer
// Optional SEQ_PERF_CNT_EN build also checks the performance counters.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic       err;
    logic       imem_rd_en;
    logic [9:0] imem_addr;
    logic [8:0] imem_data;
    logic [8:0] instr;
    logic       instr_valid;
    logic       commit;
    logic       branch_en;
    logic [4:0] branch_idx;
    logic       mem_access;
    logic       dmem_req;
    logic       dmem_ack;
    logic       lut_wr_en;
    logic [4:0] lut_wr_idx;
    logic [9:0] lut_wr_data;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cyc_cnt;
    logic [31:0] instr_cnt;
`endif

    logic [8:0] imem [1024];

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .err         (err),
        .imem_rd_en  (imem_rd_en),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .commit      (commit),
        .branch_en   (branch_en),
        .branch_idx  (branch_idx),
        .mem_access  (mem_access),
        .dmem_req    (dmem_req),
        .dmem_ack    (dmem_ack),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_idx  (lut_wr_idx),
`ifdef SEQ_PERF_CNT_EN
        .cyc_cnt     (cyc_cnt),
        .instr_cnt   (instr_cnt),
`endif
        .lut_wr_data (lut_wr_data)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (imem_rd_en) imem_data <= imem[imem_addr];
    end

    typedef struct {
        logic       start;
        logic       mem_access;
        logic       branch_en;
        logic [4:0] branch_idx;
        logic       dmem_ack;
        logic       lut_wr_en;
        logic [4:0] lut_wr_idx;
        logic [9:0] lut_wr_data;
        logic       e_rd;
        logic       e_iv;
        logic       e_commit;
        logic       e_req;
        logic       e_done;
        logic       e_err;
        logic [9:0] e_addr;
        logic [8:0] e_instr;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(int st, int ma, int be, int bi, int ak, int lw, int li, int ld,
                                int rd, int iv, int cm, int rq, int dn, int er, int ad, int ins);
        vec_t v;
        v.start       = st[0];
        v.mem_access  = ma[0];
        v.branch_en   = be[0];
        v.branch_idx  = bi[4:0];
        v.dmem_ack    = ak[0];
        v.lut_wr_en   = lw[0];
        v.lut_wr_idx  = li[4:0];
        v.lut_wr_data = ld[9:0];
        v.e_rd        = rd[0];
        v.e_iv        = iv[0];
        v.e_commit    = cm[0];
        v.e_req       = rq[0];
        v.e_done      = dn[0];
        v.e_err       = er[0];
        v.e_addr      = ad[9:0];
        v.e_instr     = ins[8:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 1'b0; branch_en = 1'b0; branch_idx = '0; mem_access = 1'b0;
        dmem_ack = 1'b0; lut_wr_en = 1'b0; lut_wr_idx = '0; lut_wr_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Entered in FETCH; leaves in the following FETCH after one ALU commit.
    task automatic run_alu(input string tag, input logic be, input logic [4:0] bi, input logic drop_wr);
        chk({tag, "_fetch"}, 32'(imem_rd_en), 32'd1);
        tick();
        tick();
        branch_en = be; branch_idx = bi;
        lut_wr_en = drop_wr; lut_wr_idx = 5'd7; lut_wr_data = 10'h2AA;
        #1;
        chk({tag, "_commit"}, 32'(commit), 32'd1);
        tick();
        branch_en = 1'b0; branch_idx = '0; lut_wr_en = 1'b0;
    endtask

    // Entered in FETCH; leaves in MEMWAIT cycle 1.
    task automatic enter_memwait(input string tag);
        tick();
        tick();
        mem_access = 1'b1;
        #1;
        chk({tag, "_exec_req"}, 32'(dmem_req), 32'd1);
        chk({tag, "_exec_nocommit"}, 32'(commit), 32'd0);
        tick();
        mem_access = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        for (int i = 0; i < 1024; i++) imem[i] = 9'h000;
        imem[0]     = 9'h012;
        imem[1]     = 9'h034;
        imem[2]     = 9'h1FF;
        imem[4]     = 9'h0C5;
        imem[5]     = 9'h1FF;
        imem[10'h3F0] = 9'h055;
        imem[10'h3FF] = 9'h066;
        imem_data = '0;
        clear_inputs();
        reset = 1'b1;
        #3;
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_rd", 32'(imem_rd_en), 32'd0);
        chk("rst_iv", 32'(instr_valid), 32'd0);
        chk("rst_commit", 32'(commit), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        //          st ma be bi ak lw li ld   rd iv cm rq dn er ad   instr
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 'h000);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 'h000);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 'h000);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 'h012);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 'h012);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 'h012);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 1, 'h034);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 2, 'h034);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2, 'h034);
        tbl[9]  = mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 2, 'h1FF);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 2, 'h1FF);
        tbl[11] = mk(1, 0, 0, 0, 0, 1, 1, 4,  0, 0, 0, 0, 1, 0, 2, 'h1FF);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 'h1FF);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 'h1FF);
        tbl[14] = mk(0, 0, 1, 1, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 'h012);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 4, 'h012);
        tbl[16] = mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 4, 'h012);
        tbl[17] = mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0, 4, 'h0C5);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0, 4, 'h0C5);
        tbl[19] = mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 1, 1, 0, 0, 4, 'h0C5);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 5, 'h0C5);
        tbl[21] = mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 5, 'h0C5);
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 5, 'h1FF);
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 5, 'h1FF);

        // Program run, halt, restart with same-cycle LUT write, branch, load.
        for (int i = 0; i < 24; i++) begin
            start       = tbl[i].start;
            mem_access  = tbl[i].mem_access;
            branch_en   = tbl[i].branch_en;
            branch_idx  = tbl[i].branch_idx;
            dmem_ack    = tbl[i].dmem_ack;
            lut_wr_en   = tbl[i].lut_wr_en;
            lut_wr_idx  = tbl[i].lut_wr_idx;
            lut_wr_data = tbl[i].lut_wr_data;
            #1;
            chk($sformatf("row%0d_rd", i), 32'(imem_rd_en), 32'(tbl[i].e_rd));
            chk($sformatf("row%0d_iv", i), 32'(instr_valid), 32'(tbl[i].e_iv));
            chk($sformatf("row%0d_commit", i), 32'(commit), 32'(tbl[i].e_commit));
            chk($sformatf("row%0d_req", i), 32'(dmem_req), 32'(tbl[i].e_req));
            chk($sformatf("row%0d_done", i), 32'(done), 32'(tbl[i].e_done));
            chk($sformatf("row%0d_err", i), 32'(err), 32'(tbl[i].e_err));
            chk($sformatf("row%0d_addr", i), 32'(imem_addr), 32'(tbl[i].e_addr));
            chk($sformatf("row%0d_instr", i), 32'(instr), 32'(tbl[i].e_instr));
            tick();
        end
        clear_inputs();
`ifdef SEQ_PERF_CNT_EN
        chk("perf_cyc_after_run", cyc_cnt, 32'd11);
        chk("perf_instr_after_run", instr_cnt, 32'd2);
`endif

        // LUT writes in IDLE, branch to far target, wrap, dropped EXEC write.
        do_reset();
        lut_wr_en = 1'b1; lut_wr_idx = 5'd7; lut_wr_data = 10'h3F0;
        tick();
        lut_wr_idx = 5'd8; lut_wr_data = 10'h3FF;
        tick();
        lut_wr_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_fetch_addr", 32'(imem_addr), 32'd0);
        run_alu("t3_a", 1'b1, 5'd7, 1'b0);
        chk("t3_branch_target", 32'(imem_addr), 32'h3F0);
        run_alu("t3_b", 1'b1, 5'd8, 1'b0);
        chk("t4_pc_max", 32'(imem_addr), 32'h3FF);
        run_alu("t4_a", 1'b0, 5'd0, 1'b1);
        chk("t4_wrap", 32'(imem_addr), 32'd0);
        run_alu("t4_b", 1'b1, 5'd7, 1'b0);
        chk("t4_write_dropped", 32'(imem_addr), 32'h3F0);

        // Data-memory timeout with no ack.
        enter_memwait("t5");
        bad = 0;
        for (int k = 1; k <= 15; k++) begin
            if (dmem_req !== 1'b1 || commit !== 1'b0 || instr_valid !== 1'b1 || err !== 1'b0) bad++;
            tick();
        end
        chk("t5_memwait_hold", 32'(bad), 32'd0);
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_req_dropped", 32'(dmem_req), 32'd0);
        chk("t5_pc_held", 32'(imem_addr), 32'h3F0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_err_cleared", 32'(err), 32'd0);
        chk("t5_restart_fetch", 32'(imem_rd_en), 32'd1);
        chk("t5_restart_addr", 32'(imem_addr), 32'd0);

        // Ack on the timeout cycle wins.
        enter_memwait("t5b");
        for (int k = 1; k < 15; k++) tick();
        dmem_ack = 1'b1;
        #1;
        chk("t5b_ack_at_tmo_commit", 32'(commit), 32'd1);
        tick();
        dmem_ack = 1'b0;
        chk("t5b_no_err", 32'(err), 32'd0);
        chk("t5b_next_fetch", 32'(imem_rd_en), 32'd1);
        chk("t5b_next_addr", 32'(imem_addr), 32'd1);

        // Asynchronous reset in the middle of MEMWAIT.
        enter_memwait("t6");
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t6_req", 32'(dmem_req), 32'd0);
        chk("t6_commit", 32'(commit), 32'd0);
        chk("t6_iv", 32'(instr_valid), 32'd0);
        chk("t6_addr", 32'(imem_addr), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
`ifdef SEQ_PERF_CNT_EN
        chk("t6_cyc_cnt", cyc_cnt, 32'd0);
        chk("t6_instr_cnt", instr_cnt, 32'd0);
`endif
        tick();
        reset = 1'b0;
        tick();
        chk("t6_idle_stays", 32'(imem_rd_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
